seq_multiplier_nbyn: RTL and testbench

//  Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/seq_multiplier_nbyn_pkg.sv | 30 +++
 rtl/seq_multiplier_nbyn_if.sv | 23 ++
 rtl/seq_multiplier_nbyn_ctrl.sv | 90 +++++++++
 rtl/seq_multiplier_nbyn.sv | 130 +++++++++++++
 tb/tb_seq_multiplier_nbyn.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_nbyn_pkg.sv
// Shared definitions for the sequential N x N shift-add multiplier:
// controller state encoding and the counter-width helper.
package seq_multiplier_nbyn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_multiplier_nbyn_if.sv
// Operand/result handshake bundle between the operand source (master)
// and the sequential multiplier (slave).
interface seq_multiplier_nbyn_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       dataa;
    logic [WIDTH-1:0]       datab;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, is_signed, dataa, datab,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, dataa, datab,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier_nbyn_ctrl.sv
// Controller for the sequential multiplier: IDLE/RUN/DONE state machine
// and the iteration counter. busy/done are registered; load, shift_en and
// last are decoded strobes that steer the datapath in the top level.
module seq_multiplier_nbyn_ctrl
    import seq_multiplier_nbyn_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic shift_en,
    output logic last
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    // Decode the datapath strobes from the current state and counter.
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        last     = 1'b0;
        if (state_r == ST_RUN) begin
            shift_en = 1'b1;
            last     = (cnt_r == LAST_CNT);
        end else if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            load = start;
        end else begin
            load     = 1'b0;
            shift_en = 1'b0;
            last     = 1'b0;
        end
    end

    // State machine, iteration counter and registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    cnt_r  <= '0;
                    if (start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= cnt_r + CW'(1'b1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/seq_multiplier_nbyn.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial
// product per clock. Signed operands are multiplied as magnitudes and the
// sign is applied to the final product. Holds the operand registers, the
// 2*WIDTH+1 bit accumulator and the result register; sequencing lives in
// seq_multiplier_nbyn_ctrl.
module seq_multiplier_nbyn
    import seq_multiplier_nbyn_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_multiplier_nbyn_if.slave  bus
);

    localparam int PW = 2 * WIDTH;

    // Magnitude of a WIDTH-bit value; the most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + WIDTH'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic               load_s;
    logic               shift_en_s;
    logic               last_s;
    logic               busy_s;
    logic               done_s;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               neg_s;

    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic               neg_r;
    logic [PW:0]        acc_r;
    logic [PW-1:0]      product_r;

    logic [WIDTH:0]     sum_s;
    logic [PW:0]        acc_next_s;
    logic [PW-1:0]      result_s;

    seq_multiplier_nbyn_ctrl #(
        .WIDTH    (WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bus.start),
        .busy     (busy_s),
        .done     (done_s),
        .load     (load_s),
        .shift_en (shift_en_s),
        .last     (last_s)
    );

    if (SIGNED_EN) begin : g_sign
        // Operand conditioning: magnitudes and result sign in signed mode.
        always_comb begin
            mag_a_s = abs_val(bus.dataa, bus.is_signed);
            mag_b_s = abs_val(bus.datab, bus.is_signed);
            neg_s   = bus.is_signed & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
        end
    end else begin : g_nosign
        logic unused_sign_s;
        // Unsigned-only build: operands pass straight through, mode ignored.
        always_comb begin
            mag_a_s       = bus.dataa;
            mag_b_s       = bus.datab;
            neg_s         = 1'b0;
            unused_sign_s = bus.is_signed;
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping the carry), then shift the whole accumulator right.
    always_comb begin
        sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
        if (mplier_r[0]) begin
            acc_next_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
        end else begin
            acc_next_s = {1'b0, acc_r[PW:1]};
        end
        if (neg_r) begin
            result_s = ~acc_next_s[PW-1:0] + PW'(1'b1);
        end else begin
            result_s = acc_next_s[PW-1:0];
        end
    end

    // Operand capture on accept, accumulate while running, result on last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= '0;
            mplier_r  <= '0;
            neg_r     <= 1'b0;
            acc_r     <= '0;
            product_r <= '0;
        end else if (load_s) begin
            mcand_r   <= mag_a_s;
            mplier_r  <= mag_b_s;
            neg_r     <= neg_s;
            acc_r     <= '0;
        end else if (shift_en_s) begin
            acc_r    <= acc_next_s;
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (last_s) begin
                product_r <= result_s;
            end else begin
                product_r <= product_r;
            end
        end else begin
            acc_r     <= acc_r;
            product_r <= product_r;
        end
    end

    assign bus.busy    = busy_s;
    assign bus.done    = done_s;
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_multiplier_nbyn.sv
// Self-checking bench for seq_multiplier_nbyn: a WIDTH=4 signed-capable
// instance (table, handshake corners, exhaustive), a WIDTH=8 instance
// (random both modes) and a WIDTH=4 unsigned-only build (exhaustive).
module tb_seq_multiplier_nbyn;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] prod;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t qu[$];

    seq_multiplier_nbyn_if #(.WIDTH(4)) m4();
    seq_multiplier_nbyn_if #(.WIDTH(8)) m8();
    seq_multiplier_nbyn_if #(.WIDTH(4)) mu();

    seq_multiplier_nbyn #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));
    seq_multiplier_nbyn #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8));
    seq_multiplier_nbyn #(.WIDTH(4), .SIGNED_EN(1'b0)) dutu (.clk(clk), .rst_n(rst_n), .bus(mu));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference product from integer arithmetic, truncated to 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input bit s);
        int ai, bi, p;
        ai = int'(a) & ((1 << w) - 1);
        bi = int'(b) & ((1 << w) - 1);
        if (s && ai >= (1 << (w - 1))) ai = ai - (1 << w);
        if (s && bi >= (1 << (w - 1))) bi = bi - (1 << w);
        p = ai * bi;
        return 16'(p & ((1 << (2 * w)) - 1));
    endfunction

    // Scoreboard monitor for the main instance, including product hold.
    logic [7:0] held4;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held4 = 8'h00;
        end else if (m4.done === 1'b1) begin
            chk("m4 done expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("m4 product", 32'(m4.product), 32'(e.prod));
                chk("m4 done cycle", 32'(cyc), 32'(e.cyc));
                chk("m4 busy at done", 32'(m4.busy), 32'd0);
            end
            held4 = m4.product;
        end else begin
            chk("m4 product hold", 32'(m4.product), 32'(held4));
        end
    end

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m8.done === 1'b1) begin
            chk("m8 done expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("m8 product", 32'(m8.product), 32'(e.prod));
                chk("m8 done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Scoreboard monitor for the unsigned-only instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mu.done === 1'b1) begin
            chk("mu done expected", 32'(qu.size() != 0), 32'd1);
            if (qu.size() != 0) begin
                e = qu.pop_front();
                chk("mu product", 32'(mu.product), 32'(e.prod));
                chk("mu done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp_v);
        @(posedge clk); #2;
        m4.start = 1'b1; m4.dataa = a; m4.datab = b; m4.is_signed = s;
        q4.push_back('{prod: 16'(exp_v), cyc: cyc + 1 + 4});
        @(posedge clk); #2;
        m4.start = 1'b0;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(posedge clk); #2;
        m8.start = 1'b1; m8.dataa = a; m8.datab = b; m8.is_signed = s;
        q8.push_back('{prod: ref_mul(8, a, b, s), cyc: cyc + 1 + 8});
        @(posedge clk); #2;
        m8.start = 1'b0;
    endtask

    task automatic driveu(input logic [3:0] a, input logic [3:0] b, input logic s);
        @(posedge clk); #2;
        mu.start = 1'b1; mu.dataa = a; mu.datab = b; mu.is_signed = s;
        qu.push_back('{prod: ref_mul(4, 8'(a), 8'(b), 1'b0), cyc: cyc + 1 + 4});
        @(posedge clk); #2;
        mu.start = 1'b0;
    endtask

    // Wait (bounded) until every outstanding result has been seen.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((q4.size() + q8.size() + qu.size()) != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard drained", 32'(q4.size() + q8.size() + qu.size()), 32'd0);
        q4.delete(); q8.delete(); qu.delete();
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{a: 4'd2,  b: 4'd8,  s: 1'b0, prod: 8'h10};
        vecs[1]  = '{a: 4'd10, b: 4'd5,  s: 1'b0, prod: 8'h32};
        vecs[2]  = '{a: 4'd15, b: 4'd15, s: 1'b0, prod: 8'hE1};
        vecs[3]  = '{a: 4'd0,  b: 4'd9,  s: 1'b0, prod: 8'h00};
        vecs[4]  = '{a: 4'h8,  b: 4'h8,  s: 1'b1, prod: 8'h40};
        vecs[5]  = '{a: 4'hD,  b: 4'h5,  s: 1'b1, prod: 8'hF1};
        vecs[6]  = '{a: 4'h7,  b: 4'hF,  s: 1'b1, prod: 8'hF9};
        vecs[7]  = '{a: 4'h8,  b: 4'h8,  s: 1'b0, prod: 8'h40};
        vecs[8]  = '{a: 4'hD,  b: 4'h5,  s: 1'b0, prod: 8'h41};
        vecs[9]  = '{a: 4'h0,  b: 4'h8,  s: 1'b1, prod: 8'h00};
        vecs[10] = '{a: 4'hF,  b: 4'hF,  s: 1'b1, prod: 8'h01};
        vecs[11] = '{a: 4'h8,  b: 4'h7,  s: 1'b1, prod: 8'hC8};

        m4.start = 1'b0; m4.is_signed = 1'b0; m4.dataa = '0; m4.datab = '0;
        m8.start = 1'b0; m8.is_signed = 1'b0; m8.dataa = '0; m8.datab = '0;
        mu.start = 1'b0; mu.is_signed = 1'b0; mu.dataa = '0; mu.datab = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", 32'(m4.busy), 32'd0);
        chk("reset done", 32'(m4.done), 32'd0);
        chk("reset product", 32'(m4.product), 32'd0);
        chk("reset m8 product", 32'(m8.product), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post-reset busy", 32'(m4.busy), 32'd0);
        chk("post-reset product", 32'(m4.product), 32'd0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            drive4(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].prod);
            wait_idle();
        end

        // Back-to-back: start held high, next op accepted in each DONE cycle
        @(posedge clk); #2;
        m4.start = 1'b1; m4.dataa = 4'd2; m4.datab = 4'd3; m4.is_signed = 1'b0;
        q4.push_back('{prod: 16'h0006, cyc: cyc + 1 + 4});
        repeat (5) @(posedge clk); #2;
        m4.dataa = 4'hF; m4.datab = 4'hE; m4.is_signed = 1'b0;
        q4.push_back('{prod: 16'h00D2, cyc: cyc + 1 + 4});
        repeat (5) @(posedge clk); #2;
        m4.dataa = 4'h9; m4.datab = 4'h9; m4.is_signed = 1'b1;
        q4.push_back('{prod: 16'h0031, cyc: cyc + 1 + 4});
        @(posedge clk); #2;
        m4.start = 1'b0;
        wait_idle();

        // Start pulsed mid-RUN with other operands is ignored
        drive4(4'd6, 4'd7, 1'b0, 8'h2A);
        @(posedge clk); #2;
        m4.start = 1'b1; m4.dataa = 4'hF; m4.datab = 4'hF;
        @(posedge clk); #2;
        m4.start = 1'b0;
        wait_idle();
        repeat (6) @(posedge clk);

        // Async reset in the second RUN cycle discards the operation
        @(posedge clk); #2;
        m4.start = 1'b1; m4.dataa = 4'd3; m4.datab = 4'd5; m4.is_signed = 1'b0;
        @(posedge clk); #2;
        m4.start = 1'b0;
        @(posedge clk); #2;
        chk("busy in run", 32'(m4.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(m4.busy), 32'd0);
        chk("async reset done", 32'(m4.done), 32'd0);
        chk("async reset product", 32'(m4.product), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        drive4(4'd3, 4'd5, 1'b0, 8'h0F);
        wait_idle();

        // Exhaustive WIDTH=4, both modes
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive4(4'(a), 4'(b), 1'(s), ref_mul(4, 8'(a), 8'(b), 1'(s)) & 16'h00FF);
                    wait_idle();
                end
            end
        end

        // WIDTH=8 corners and random, both modes
        drive8(8'h80, 8'h80, 1'b1); wait_idle();
        drive8(8'hFF, 8'hFF, 1'b0); wait_idle();
        drive8(8'h7F, 8'h80, 1'b1); wait_idle();
        for (int i = 0; i < 300; i++) begin
            drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(i & 1));
            wait_idle();
        end

        // Unsigned-only build: is_signed must have no effect
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                driveu(4'(a), 4'(b), 1'($urandom_range(0, 1)));
                wait_idle();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
